// File: rtl/alu_operand_stack.sv
// alu_operand_stack: evaluation stack feeding the ALU; optional second-result push via ALU_OPSTACK_DUAL_RESULT_EN
module alu_operand_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               opCode,
  input  logic                     binary,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushValue,
  input  logic                     pop,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [WIDTH-1:0]         aluIn1,
  output logic [WIDTH-1:0]         aluIn2,
  output logic [2:0]               aluOpCode,
  output logic                     aluEnable,
  input  logic [WIDTH-1:0]         aluOut1,
  input  logic [WIDTH-1:0]         aluOut2,
  input  logic                     aluNext
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH2} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  in1_q, in1_d, in2_q, in2_d;
  logic [2:0]        op_q, op_d;
  logic              en_q, en_d, done_q, done_d, err_q, err_d, bin_q, bin_d;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic [CW-1:0]     need;
  logic [WIDTH-1:0]  below;
  logic              dual;
  assign need  = binary ? CW'(2) : CW'(1);
  assign top   = (count_q == '0) ? '0 : mem_q[AW'(count_q - CW'(1))];
  assign below = mem_q[AW'(count_q - CW'(2))];
`ifdef ALU_OPSTACK_DUAL_RESULT_EN
  assign dual = bin_q && (op_q == 3'd0 || op_q == 3'd2);
`else
  logic unused_bin;
  assign unused_bin = bin_q;
  assign dual = 1'b0;
`endif
  assign count     = count_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign aluIn1    = in1_q;
  assign aluIn2    = in2_q;
  assign aluOpCode = op_q;
  assign aluEnable = en_q;
  // Next-state, stack write port and pulse generation
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    bin_d   = bin_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = AW'(count_q);
    wr_data = pushValue;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = push | pop | (count_q < need);
          if (count_q >= need) begin
            in1_d   = top;
            in2_d   = binary ? below : '0;
            op_d    = opCode;
            bin_d   = binary;
            count_d = count_q - need;
            en_d    = 1'b1;
            state_d = ISSUE;
          end
        end else if (pop) begin
          err_d   = push | (count_q == '0);
          count_d = (count_q == '0) ? count_q : count_q - CW'(1);
        end else if (push) begin
          err_d   = (count_q == CW'(DEPTH));
          wr_en   = (count_q != CW'(DEPTH));
          count_d = wr_en ? count_q + CW'(1) : count_q;
        end
      end
      ISSUE: begin
        err_d   = start | push | pop;
        state_d = WAIT;
      end
      WAIT: begin
        err_d = start | push | pop;
        if (aluNext) begin
          wr_en   = 1'b1;
          wr_data = aluOut1;
          count_d = count_q + CW'(1);
          done_d  = !dual;
          state_d = dual ? PUSH2 : IDLE;
        end
      end
      default: begin
        err_d   = start | push | pop;
        wr_en   = 1'b1;
        wr_data = aluOut2;
        count_d = count_q + CW'(1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // Control and ALU-facing registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      bin_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // Stack storage; contents survive reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_alu_operand_stack.sv
// tb_alu_operand_stack: directed checks of the operand stack with a behavioural ALU responder
module tb_alu_operand_stack;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, binary = 1'b0, push = 1'b0, pop = 1'b0;
  logic [2:0]  opCode = '0;
  logic [31:0] pushValue = '0;
  logic [31:0] top, aluIn1, aluIn2;
  logic [4:0]  count;
  logic        busy, done, err, aluEnable;
  logic [2:0]  aluOpCode;
  logic [31:0] aluOut1 = '0, aluOut2 = '0;
  logic        aluNext = 1'b0;
  int          total = 0, bad = 0, lat;

  alu_operand_stack #(.DEPTH(16), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .opCode(opCode), .binary(binary),
    .push(push), .pushValue(pushValue), .pop(pop), .top(top), .count(count),
    .busy(busy), .done(done), .err(err), .aluIn1(aluIn1), .aluIn2(aluIn2),
    .aluOpCode(aluOpCode), .aluEnable(aluEnable), .aluOut1(aluOut1),
    .aluOut2(aluOut2), .aluNext(aluNext)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] clz(input logic [31:0] v);
    logic [31:0] n = 32;
    for (int i = 31; i >= 0; i--) if (v[i] && n == 32) n = 31 - i;
    return n;
  endfunction

  // ALU stand-in: sees enable, raises next on the falling edge two cycles later for one cycle
  initial forever begin
    @(negedge clk);
    if (aluEnable === 1'b1) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [63:0] w;
      a = aluIn1; b = aluIn2; op = aluOpCode;
      @(negedge clk);
      @(negedge clk);
      w = (op == 3'd0) ? {32'd0, a} + {32'd0, b} :
          (op == 3'd1) ? {32'd0, clz(a)} :
          (op == 3'd2) ? {32'd0, a} << b[4:0] : {32'd0, a ^ b};
      aluOut1 = w[31:0];
      aluOut2 = w[63:32];
      aluNext = 1'b1;
      @(negedge clk);
      aluNext = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [31:0] v);
    push = 1'b1; pushValue = v;
    tick();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] op, input logic bin);
    start = 1'b1; opCode = op; binary = bin;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic clear();
    for (int g = 0; g < 40 && count !== 5'd0; g++) do_pop();
  endtask

  initial begin
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_top", top, 0);
    chk("rst_en", 32'(aluEnable), 0);
    chk("rst_in1", aluIn1, 0);
    rst = 1'b0;
    // binary add 7 + 5
    do_push(5);
    do_push(7);
    chk("push_count", 32'(count), 2);
    chk("push_top", top, 7);
    do_start(3'd0, 1'b1);
    chk("add_in1", aluIn1, 7);
    chk("add_in2", aluIn2, 5);
    chk("add_en", 32'(aluEnable), 1);
    chk("add_busy", 32'(busy), 1);
    chk("add_popped", 32'(count), 0);
    tick();
    chk("add_en_drop", 32'(aluEnable), 0);
    wait_done(lat);
    lat++;
`ifdef ALU_OPSTACK_DUAL_RESULT_EN
    chk("add_lat", lat, 4);
    chk("add_count", 32'(count), 2);
    chk("add_top", top, 0);
`else
    chk("add_lat", lat, 3);
    chk("add_count", 32'(count), 1);
    chk("add_top", top, 12);
`endif
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("idle", 32'(busy), 0);
    clear();
    // unary CLZ
    do_push(32'h0000FFFF);
    do_start(3'd1, 1'b0);
    chk("clz_in2", aluIn2, 0);
    chk("clz_in1", aluIn1, 32'h0000FFFF);
    wait_done(lat);
    chk("clz_lat", lat, 3);
    chk("clz_top", top, 16);
    chk("clz_count", 32'(count), 1);
    clear();
    // carry-producing add
    do_push(32'hFFFFFFFF);
    do_push(1);
    do_start(3'd0, 1'b1);
    wait_done(lat);
`ifdef ALU_OPSTACK_DUAL_RESULT_EN
    chk("dual_lat", lat, 4);
    chk("dual_count", 32'(count), 2);
    chk("dual_top", top, 1);
    do_pop();
`else
    chk("dual_lat", lat, 3);
`endif
    chk("dual_count1", 32'(count), 1);
    chk("dual_low", top, 0);
    // binary start with one entry
    do_start(3'd0, 1'b1);
    chk("under_err", 32'(err), 1);
    chk("under_en", 32'(aluEnable), 0);
    chk("under_busy", 32'(busy), 0);
    chk("under_count", 32'(count), 1);
    tick();
    chk("err_pulse", 32'(err), 0);
    do_pop();
    do_pop();
    chk("pop_empty_err", 32'(err), 1);
    chk("pop_empty_count", 32'(count), 0);
    // overflow
    for (int i = 0; i < 17; i++) begin
      do_push(i);
      if (i == 15) chk("full_no_err", 32'(err), 0);
    end
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_top", top, 15);
    clear();
    // start and push together, then push while busy
    do_push(3);
    do_push(4);
    start = 1'b1; opCode = 3'd0; binary = 1'b1; push = 1'b1; pushValue = 99;
    tick();
    start = 1'b0; push = 1'b0;
    chk("conf_err", 32'(err), 1);
    chk("conf_en", 32'(aluEnable), 1);
    chk("conf_count", 32'(count), 0);
    do_push(55);
    chk("busy_err", 32'(err), 1);
    chk("busy_count", 32'(count), 0);
    wait_done(lat);
    chk("conf_done", 32'(done), 1);
`ifdef ALU_OPSTACK_DUAL_RESULT_EN
    chk("conf_res_count", 32'(count), 2);
    chk("conf_res_top", top, 0);
`else
    chk("conf_res_count", 32'(count), 1);
    chk("conf_res_top", top, 7);
`endif
    clear();
    // reset in the middle of WAIT
    do_push(2);
    do_push(3);
    do_start(3'd0, 1'b1);
    tick();
    chk("wait_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_in1", aluIn1, 0);
    chk("mid_rst_in2", aluIn2, 0);
    chk("mid_rst_top", top, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stray_next_count", 32'(count), 0);
      chk("stray_next_done", 32'(done), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_stack.md
# alu_operand_stack

Operand-stack front end for the ALU in the home-made CPU. It holds the evaluation stack and pops one or two operands. It registers them onto the ALU's `in1`/`in2`/`opCode` inputs and pulses the ALU `enable`. It then waits for the ALU's `next` completion strobe and pushes `out1` back onto the stack, and optionally `out2` as well. The instruction sequencer sees one `start` → `done` transaction per ALU operation and can also push, pop and peek the stack directly while the block is idle.

## Interface
Parameters:
- `DEPTH`, 16: number of stack entries (power of two, ≥4).
- `WIDTH`, 32: entry width; must equal the ALU data width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request an ALU operation; sampled only in IDLE.
- `opCode`  in  3  ALU function for this operation.
- `binary`  in  1  1 = pop two operands; 0 = pop one operand (`aluIn2` = 0).
- `push`  in  1  push `pushValue` (IDLE only).
- `pushValue`  in  WIDTH  data for `push`.
- `pop`  in  1  discard top entry (IDLE only).
- `top`  out  WIDTH  current top entry; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the operation's result is on the stack.
- `err`  out  1  one-cycle pulse on a rejected request.
- `aluIn1`, `aluIn2`  out  WIDTH  registered ALU operands.
- `aluOpCode`  out  3  registered ALU function.
- `aluEnable`  out  1  one-cycle ALU start pulse.
- `aluOut1`, `aluOut2`  in  WIDTH  ALU results; held stable by the ALU until its next `enable`.
- `aluNext`  in  1  ALU completion strobe.

## Operation
- Storage is a register array indexed by `count`. Entry `count-1` is the top.
- FSM states: IDLE → ISSUE → WAIT → (PUSH2) → IDLE.
- IDLE request priority: `start` > `pop` > `push`.
  - Only the highest-priority asserted request is serviced.
  - Each lower-priority request asserted in the same cycle is dropped, and `err` pulses once.
- `start` with `count` ≥ (`binary`? 2 : 1):
  - `aluIn1` ← top.
  - `aluIn2` ← entry below top if `binary`, else 0.
  - `aluOpCode` ← `opCode`.
  - `count` -= 1 or 2.
  - `aluEnable` ← 1; go to ISSUE.
- `start` with too few entries: `err` pulses, no state change, no `aluEnable`.
- ISSUE: `aluEnable` ← 0; go to WAIT.
- WAIT: on `aluNext` sampled high:
  - write `aluOut1` at index `count`; `count` += 1.
  - If the second-result condition holds (see Configuration), go to PUSH2.
  - Otherwise pulse `done` and go to IDLE.
- PUSH2: write `aluOut2`; `count` += 1; pulse `done`; go to IDLE.
- Because an operation pops at least as many entries as it pushes, result pushes never overflow.
- `push` when `count` == DEPTH: ignored, `err` pulses.
- `pop` when `count` == 0: ignored, `err` pulses.
- `push`, `pop` or `start` while `busy`: ignored, `err` pulses.
- `top` is combinational from the array and `count`.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `count` 0.
  - `aluIn1`, `aluIn2`, `aluOpCode`, `aluEnable`, `done`, `err` all 0; `busy` 0; `top` 0.
  - Array contents need not be cleared.
- Reset during ISSUE/WAIT/PUSH2 aborts the operation. A later stray `aluNext` in IDLE is ignored.
- Cycle-level sequence, with `start` accepted at edge T:
  - `aluEnable` is high for cycle T..T+1 only.
  - The ALU samples `aluEnable` at edge T+1 and asserts `aluNext` on the falling edge inside cycle T+2..T+3, for one full cycle.
  - `aluNext` is first sampled high at edge T+3.
  - Result 1 is on the stack, and `done` is high, after edge T+3.
  - With a second result, `done` comes one cycle later, after edge T+4.
- `aluNext` is sampled in WAIT only. It is high for exactly one sampling edge, so no edge detector is required.
- `push`/`pop` take effect at the sampling edge. `top` and `count` update in the same cycle.

## Configuration
- `ALU_OPSTACK_DUAL_RESULT_EN` defined:
  - The second-result condition is `binary` & (`aluOpCode` == 0 (add: carry) or `aluOpCode` == 2 (shift: high word)).
  - In that case `aluOut2` is pushed after `aluOut1`, leaving `aluOut2` on top.
- `ALU_OPSTACK_DUAL_RESULT_EN` undefined:
  - PUSH2 is never entered; only `aluOut1` is pushed.
  - `aluOut2` is unused.

## Test plan
- Reset value: assert `rst` mid-WAIT → outputs zero at once, `count` 0, and the following `aluNext` pulse has no effect.
- Binary add without `ALU_OPSTACK_DUAL_RESULT_EN`:
  - Setup: push 5, push 7; `start` with op 0, `binary` 1.
  - Required: `aluIn1`=7, `aluIn2`=5; `done` 4 cycles after `start`; `count`=1, `top`=12.
- Unary with `ALU_OPSTACK_DUAL_RESULT_EN`:
  - Setup: push 0x0000FFFF; `start` with op 1 (CLZ), `binary` 0.
  - Required: `aluIn2`=0; single push; `top`=16; `count`=1.
- Dual result with `ALU_OPSTACK_DUAL_RESULT_EN`:
  - Setup: push 0xFFFFFFFF, push 1; `start` with op 0, `binary` 1.
  - Required: stack holds 0 then 1 (top), `count`=2; `done` 5 cycles after `start`.
- Underflow/overflow:
  - `start` with `binary` 1 at `count`=1 → `err` pulse, no `aluEnable`, `count` 1.
  - DEPTH+1 pushes → last one rejected with `err`, `count`=DEPTH.
- Conflicts:
  - `start` and `push` in the same cycle → operation runs, push dropped, one `err` pulse.
  - `push` while `busy` → `err`, stack unchanged.
